apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single APB master (apbSubSystem) between NUM_REQ
//  requesters, e.g. cpu plus a DMA/debug port. Latches the winner's sel/addr/wdata,
//  drives the master enable until ready, then returns rdata to the winner as a done pulse.
//  Adds a per-transfer timeout so a hung peripheral cannot lock the bus.
// PARAMETERS
//  NUM_REQ  2    number of requesters (2..8)
//  SEL_W    8    peripheral select width (matches CPUSEL)
//  ADDR_W   8    address width
//  DATA_W   21   read/write data width
//  TIMEOUT  255  max BUSY cycles waiting for m_ready before abort (>=1)
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  reset      in   1               synchronous, active-high
//  req_valid  in   NUM_REQ         per-requester transfer request, held until its req_done
//  req_sel    in   NUM_REQ*SEL_W   packed selects, requester i at [i*SEL_W +: SEL_W]
//  req_addr   in   NUM_REQ*ADDR_W  packed addresses
//  req_wdata  in   NUM_REQ*DATA_W  packed write data
//  req_done   out  NUM_REQ         one-hot, 1-cycle completion pulse to granted requester
//  resp_rdata out  DATA_W          read data, valid only while req_done!=0
//  resp_err   out  1               timeout flag, valid only while req_done!=0
//  busy       out  1               high in BUSY and RESP
//  m_enable   out  1               to APB master enable
//  m_sel      out  SEL_W           to APB master select
//  m_addr     out  ADDR_W          to APB master address
//  m_wdata    out  DATA_W          to APB master data
//  m_ready    in   1               transfer complete from APB master
//  m_rdata    in   DATA_W          read data from APB master, sampled when m_ready=1
// BEHAVIOUR
//  - Reset: state=IDLE, every output 0, timeout count 0, last_grant=NUM_REQ-1 so req 0
//    wins first. Reset mid-transfer: IDLE on next edge, m_enable low, no req_done.
//  - FSM IDLE -> BUSY -> RESP -> IDLE; all outputs registered.
//  - IDLE: if any req_valid, grant first set bit searching last_grant+1, +2, ... modulo
//    NUM_REQ. Latch grant_id and its sel/addr/wdata into m_* regs; count=0; go BUSY.
//    No request: stay IDLE, m_* held at 0.
//  - BUSY: m_enable=1, m_* stable. m_ready=1: capture m_rdata, err=0, go RESP.
//    Otherwise count+1; m_ready still 0 once count reaches TIMEOUT-1 (TIMEOUT BUSY cycles
//    total): rdata=0, err=1, go RESP. m_ready in the final BUSY cycle wins over timeout.
//  - RESP: m_enable=0; req_done[grant_id]=1, resp_rdata/resp_err driven for exactly one
//    cycle; last_grant=grant_id; go IDLE. Outside RESP, resp_rdata=0 and resp_err=0.
//  - Latency: req_valid sampled in IDLE cycle N -> m_enable high from N+1; m_ready at
//    cycle M -> req_done at M+1. Minimum 3 cycles per transfer, no back-to-back overlap.
//  - req_valid changes and m_ready while not in BUSY are ignored; payload changes after
//    grant do not affect the transfer in flight.
//  - Requester drops req_valid the cycle after req_done; if still high in the next IDLE
//    it is a new request, arbitrated behind other pending requesters (round-robin).
//  - Round-robin pointer is updated only on completion (including timeout), not on grant.
// TESTING
//  - Reset, then req_valid=01, sel=8'h02, addr=8'h10, wdata=21'h1ABCD, m_ready after 2 BUSY
//    cycles with m_rdata=21'h00055 -> m_enable 2 cycles, m_* match, req_done=01, rdata=21'h00055, err=0.
//  - req_valid=11 held continuously, m_ready=1 in the first BUSY cycle -> grants alternate
//    0,1,0,1; req_done pulses every 3 cycles.
//  - TIMEOUT=4, m_ready never asserted -> m_enable high exactly 4 cycles, then req_done
//    pulses with err=1, rdata=0; next request proceeds normally.
//  - m_ready in the 4th (last) BUSY cycle with TIMEOUT=4 -> err=0, m_rdata returned.
//  - reset asserted in the 2nd BUSY cycle -> next cycle m_enable=0, busy=0, req_done=0;
//    after release, req 0 wins over pending req 1.
//  - Change req 0 addr from 8'h10 to 8'h20 during BUSY -> m_addr stays 8'h10 to completion.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters.
// Each transfer runs IDLE -> BUSY -> RESP, and a hung peripheral is aborted after TIMEOUT BUSY cycles.
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SEL_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 21,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_err,
  output logic                        busy,
  output logic                        m_enable,
  output logic [SEL_W-1:0]            m_sel,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  input  logic                        m_ready,
  input  logic [DATA_W-1:0]           m_rdata
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

  state_t              r_state,     w_state_nx;
  logic [GW-1:0]       r_grant_id,  w_grant_nx;
  logic [GW-1:0]       r_last,      w_last_nx;
  logic [CW-1:0]       r_count,     w_count_nx;
  logic                r_m_enable,  w_m_enable_nx;
  logic [SEL_W-1:0]    r_m_sel,     w_m_sel_nx;
  logic [ADDR_W-1:0]   r_m_addr,    w_m_addr_nx;
  logic [DATA_W-1:0]   r_m_wdata,   w_m_wdata_nx;
  logic [NUM_REQ-1:0]  r_req_done,  w_req_done_nx;
  logic [DATA_W-1:0]   r_rdata,     w_rdata_nx;
  logic                r_err,       w_err_nx;
  logic                r_busy;

  logic                w_found;
  logic [GW-1:0]       w_idx;
  logic [GW-1:0]       w_pick;
  logic [SEL_W-1:0]    w_pick_sel;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [DATA_W-1:0]   w_pick_wdata;

  // Round-robin search starting one past the last completed grant, wrapping at NUM_REQ.
  always_comb begin
    w_found      = 1'b0;
    w_pick       = '0;
    w_idx        = r_last;
    w_pick_sel   = '0;
    w_pick_addr  = '0;
    w_pick_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == GW'(NUM_REQ - 1)) ? '0 : w_idx + GW'(1);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_pick_sel   = req_sel[i*SEL_W +: SEL_W];
        w_pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_pick_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant_id;
    w_last_nx     = r_last;
    w_count_nx    = r_count;
    w_m_enable_nx = 1'b0;
    w_m_sel_nx    = r_m_sel;
    w_m_addr_nx   = r_m_addr;
    w_m_wdata_nx  = r_m_wdata;
    w_req_done_nx = '0;
    w_rdata_nx    = '0;
    w_err_nx      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx    = S_BUSY;
          w_grant_nx    = w_pick;
          w_count_nx    = '0;
          w_m_enable_nx = 1'b1;
          w_m_sel_nx    = w_pick_sel;
          w_m_addr_nx   = w_pick_addr;
          w_m_wdata_nx  = w_pick_wdata;
        end else begin
          w_m_sel_nx   = '0;
          w_m_addr_nx  = '0;
          w_m_wdata_nx = '0;
        end
      end
      S_BUSY: begin
        // A ready in the final allowed cycle beats the timeout.
        if (m_ready) begin
          w_state_nx    = S_RESP;
          w_rdata_nx    = m_rdata;
          w_req_done_nx = NUM_REQ'(1) << r_grant_id;
        end else if (r_count == CW'(TIMEOUT - 1)) begin
          w_state_nx    = S_RESP;
          w_err_nx      = 1'b1;
          w_req_done_nx = NUM_REQ'(1) << r_grant_id;
        end else begin
          w_count_nx    = r_count + CW'(1);
          w_m_enable_nx = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nx   = S_IDLE;
        w_last_nx    = r_grant_id;
        w_m_sel_nx   = '0;
        w_m_addr_nx  = '0;
        w_m_wdata_nx = '0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_last     <= GW'(NUM_REQ - 1);
      r_count    <= '0;
      r_m_enable <= 1'b0;
      r_m_sel    <= '0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_req_done <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_grant_id <= w_grant_nx;
      r_last     <= w_last_nx;
      r_count    <= w_count_nx;
      r_m_enable <= w_m_enable_nx;
      r_m_sel    <= w_m_sel_nx;
      r_m_addr   <= w_m_addr_nx;
      r_m_wdata  <= w_m_wdata_nx;
      r_req_done <= w_req_done_nx;
      r_rdata    <= w_rdata_nx;
      r_err      <= w_err_nx;
      r_busy     <= (w_state_nx != S_IDLE);
    end
  end

  assign req_done   = r_req_done;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign busy       = r_busy;
  assign m_enable   = r_m_enable;
  assign m_sel      = r_m_sel;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized transfers checked against a transaction-level round-robin model.
module tb_apb_req_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_sel;
  logic [15:0] req_addr;
  logic [41:0] req_wdata;
  logic [1:0]  req_done;
  logic [20:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        m_enable;
  logic [7:0]  m_sel;
  logic [7:0]  m_addr;
  logic [20:0] m_wdata;
  logic        m_ready;
  logic [20:0] m_rdata;

  logic [7:0]  sel_a   [2];
  logic [7:0]  addr_a  [2];
  logic [20:0] wdata_a [2];

  int n_checks = 0;
  int n_errors = 0;

  assign req_sel   = {sel_a[1], sel_a[0]};
  assign req_addr  = {addr_a[1], addr_a[0]};
  assign req_wdata = {wdata_a[1], wdata_a[0]};

  apb_req_arbiter #(
    .NUM_REQ(2), .SEL_W(8), .ADDR_W(8), .DATA_W(21), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .m_enable(m_enable), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    int          ready_at;  // BUSY cycle (1-based) in which m_ready is raised; 0 = never
    logic [20:0] rd;
    int          eg;
    int          een;
    logic        eerr;
    logic [20:0] erd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    m_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_default_payload();
    sel_a[0] = 8'h02; addr_a[0] = 8'h10; wdata_a[0] = 21'h1ABCD;
    sel_a[1] = 8'h05; addr_a[1] = 8'h33; wdata_a[1] = 21'h0F0F0;
  endtask

  // One complete transfer from IDLE, checking latency, master-side payload,
  // enable length, completion pulse, response data and the return to IDLE.
  task automatic do_xfer(input logic [1:0] rv, input int ready_at, input logic [20:0] rd,
                         input int eg, input int een, input logic eerr, input logic [20:0] erd,
                         input string tag);
    int         en_cycles;
    bit         got;
    logic [1:0] exp_done;
    exp_done  = 2'(1 << eg);
    en_cycles = 0;
    got       = 1'b0;
    req_valid = rv;
    m_ready   = 1'($urandom);
    m_rdata   = 21'($urandom);
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (c == 0) check({tag, " en_latency"}, 32'(m_enable), 32'd1);
      if (m_enable) begin
        en_cycles++;
        check({tag, " m_sel"},   32'(m_sel),   32'(sel_a[eg]));
        check({tag, " m_addr"},  32'(m_addr),  32'(addr_a[eg]));
        check({tag, " m_wdata"}, 32'(m_wdata), 32'(wdata_a[eg]));
        m_ready = (en_cycles == ready_at);
        m_rdata = (en_cycles == ready_at) ? rd : 21'($urandom);
      end else if (req_done != 2'b00) begin
        got = 1'b1;
        check({tag, " req_done"},  32'(req_done),   32'(exp_done));
        check({tag, " en_cycles"}, 32'(en_cycles),  32'(een));
        check({tag, " resp_err"},  32'(resp_err),   32'(eerr));
        check({tag, " resp_rdata"}, 32'(resp_rdata), 32'(erd));
        check({tag, " busy_resp"}, 32'(busy),       32'd1);
      end
    end
    if (!got) check({tag, " done_seen"}, 32'd0, 32'd1);
    req_valid = 2'b00;
    m_ready   = 1'($urandom);
    tick();
    check({tag, " idle_busy"},  32'(busy),       32'd0);
    check({tag, " idle_done"},  32'(req_done),   32'd0);
    check({tag, " idle_rdata"}, 32'(resp_rdata), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    int          pulses;
    int          last_cyc;
    int          last;
    int          grant;
    int          ready_at;
    int          een;
    logic        eerr;
    logic [1:0]  rv;
    logic [20:0] rd;

    reset = 1'b1; req_valid = 2'b00; m_ready = 1'b0; m_rdata = '0;
    set_default_payload();

    vecs[0] = '{rv: 2'b01, ready_at: 2, rd: 21'h00055,  eg: 0, een: 2, eerr: 1'b0, erd: 21'h00055};
    vecs[1] = '{rv: 2'b11, ready_at: 1, rd: 21'h12345,  eg: 1, een: 1, eerr: 1'b0, erd: 21'h12345};
    vecs[2] = '{rv: 2'b01, ready_at: 0, rd: 21'h1ABCD,  eg: 0, een: 4, eerr: 1'b1, erd: 21'h00000};
    vecs[3] = '{rv: 2'b10, ready_at: 4, rd: 21'h1FFFFF, eg: 1, een: 4, eerr: 1'b0, erd: 21'h1FFFFF};
    vecs[4] = '{rv: 2'b11, ready_at: 3, rd: 21'h00001,  eg: 0, een: 3, eerr: 1'b0, erd: 21'h00001};
    vecs[5] = '{rv: 2'b11, ready_at: 0, rd: 21'h0BEEF,  eg: 1, een: 4, eerr: 1'b1, erd: 21'h00000};
    vecs[6] = '{rv: 2'b11, ready_at: 5, rd: 21'h0CAFE,  eg: 0, een: 4, eerr: 1'b1, erd: 21'h00000};
    vecs[7] = '{rv: 2'b10, ready_at: 1, rd: 21'h0ABCD,  eg: 1, een: 1, eerr: 1'b0, erd: 21'h0ABCD};

    // Reset state
    tick(); tick(); tick();
    check("rst m_enable", 32'(m_enable),   32'd0);
    check("rst busy",     32'(busy),       32'd0);
    check("rst req_done", 32'(req_done),   32'd0);
    check("rst rdata",    32'(resp_rdata), 32'd0);
    check("rst err",      32'(resp_err),   32'd0);
    check("rst m_addr",   32'(m_addr),     32'd0);
    reset = 1'b0;
    tick();
    check("idle m_sel", 32'(m_sel), 32'd0);

    // Directed vector table (starting from reset, req 0 has priority)
    for (int i = 0; i < 8; i++)
      do_xfer(vecs[i].rv, vecs[i].ready_at, vecs[i].rd, vecs[i].eg, vecs[i].een,
              vecs[i].eerr, vecs[i].erd, $sformatf("vec%0d", i));

    // Both requesting continuously with m_ready held high: grants alternate every 3 cycles
    do_reset();
    req_valid = 2'b11; m_ready = 1'b1; m_rdata = 21'h0A0A0;
    pulses = 0; last_cyc = 0;
    for (int c = 0; c < 20 && pulses < 4; c++) begin
      tick();
      if (req_done != 2'b00) begin
        check($sformatf("alt%0d grant", pulses), 32'(req_done), (pulses % 2 == 0) ? 32'd1 : 32'd2);
        check($sformatf("alt%0d rdata", pulses), 32'(resp_rdata), 32'h0A0A0);
        if (pulses > 0) check($sformatf("alt%0d spacing", pulses), 32'(c - last_cyc), 32'd3);
        last_cyc = c;
        pulses++;
      end
    end
    check("alt pulse_count", 32'(pulses), 32'd4);
    req_valid = 2'b00; m_ready = 1'b0;
    tick(); tick();

    // Reset in the 2nd BUSY cycle; afterwards req 0 must win again
    do_xfer(2'b01, 1, 21'h00777, 0, 1, 1'b0, 21'h00777, "pre_rst");
    req_valid = 2'b11;
    tick();
    check("mid_rst busy1 en",  32'(m_enable), 32'd1);
    check("mid_rst busy1 sel", 32'(m_sel),    32'(sel_a[1]));
    tick();
    check("mid_rst busy2 en", 32'(m_enable), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst en",     32'(m_enable), 32'd0);
    check("mid_rst busy",   32'(busy),     32'd0);
    check("mid_rst done",   32'(req_done), 32'd0);
    check("mid_rst m_addr", 32'(m_addr),   32'd0);
    reset = 1'b0;
    do_xfer(2'b11, 2, 21'h00321, 0, 2, 1'b0, 21'h00321, "post_rst");

    // Payload change during BUSY does not disturb the transfer in flight
    req_valid = 2'b01;
    tick();
    check("hold busy1 m_addr", 32'(m_addr), 32'h10);
    addr_a[0] = 8'h20;
    tick();
    check("hold busy2 m_addr", 32'(m_addr), 32'h10);
    m_ready = 1'b1; m_rdata = 21'h13579;
    tick();
    check("hold done",  32'(req_done),   32'd1);
    check("hold rdata", 32'(resp_rdata), 32'h13579);
    req_valid = 2'b00; m_ready = 1'b0;
    tick();
    set_default_payload();

    // Randomized transfers vs transaction-level model
    do_reset();
    last = 1;
    for (int t = 0; t < 40; t++) begin
      sel_a[0]   = 8'($urandom);  sel_a[1]   = 8'($urandom);
      addr_a[0]  = 8'($urandom);  addr_a[1]  = 8'($urandom);
      wdata_a[0] = 21'($urandom); wdata_a[1] = 21'($urandom);
      rv       = 2'($urandom_range(1, 3));
      ready_at = $urandom_range(0, 6);
      rd       = 21'($urandom);
      grant    = -1;
      for (int k = 1; k <= 2; k++)
        if (grant < 0 && rv[(last + k) % 2]) grant = (last + k) % 2;
      eerr = !(ready_at >= 1 && ready_at <= TO);
      een  = eerr ? TO : ready_at;
      do_xfer(rv, ready_at, rd, grant, een, eerr, eerr ? 21'h0 : rd, $sformatf("rnd%0d", t));
      last = grant;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
